// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle control unit for the CPU datapath.
// Fetches an instruction, decodes the IR returned by the datapath, and then
// steps register-register ALU instructions (binary and unary) and HALT.
// All enables are decoded from the current state and the IR fields. While
// clear is low every output is forced to zero, including the T0 decode.
module control_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int NREG     = 16
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic            mem_ready,
  input  logic [31:0]     IR,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            PCout,
  output logic            PCin,
  output logic            MARin,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            MDMuxread,
  output logic            mem_read,
  output logic            IncPC,
  output logic            Zhighin,
  output logic            Zlowin,
  output logic            Zhighout,
  output logic            Zlowout,
  output logic            HIin,
  output logic            LOin,
  output logic [12:0]     alu_op,
  output logic            halted,
  output logic            fault
);

  // The wait counter only has to hold 0..WAIT_MAX-1; the cycle that would
  // reach WAIT_MAX goes to FAULT instead of incrementing.
  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_MAX - 1);
  localparam logic [NREG-1:0] REG_ONE = NREG'(1);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // Bit positions inside the one-hot alu_op vector.
  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_MUL  = 2;
  localparam int ALU_DIV  = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_OR   = 5;
  localparam int ALU_SHR  = 6;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 8;
  localparam int ALU_ROR  = 9;
  localparam int ALU_ROL  = 10;
  localparam int ALU_NEG  = 11;
  localparam int ALU_NOT  = 12;

  typedef enum logic [3:0] {
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT,
    S_FAULT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [4:0]      opcode;
  logic [3:0]      ra, rb, rc;
  logic [NREG-1:0] ra_onehot, rb_onehot, rc_onehot;
  logic [12:0]     op_bits;
  logic            is_binary, is_unary, is_muldiv, is_halt;
  logic            unused_ir_bits;

  assign opcode = IR[31:27];
  assign ra     = IR[26:23];
  assign rb     = IR[22:19];
  assign rc     = IR[18:15];

  assign ra_onehot = REG_ONE << ra;
  assign rb_onehot = REG_ONE << rb;
  assign rc_onehot = REG_ONE << rc;

  // The low IR bits carry immediates that this unit never looks at.
  assign unused_ir_bits = ^IR[14:0];

  // Classify the opcode and pick its ALU strobe; unknown opcodes are NOPs.
  always_comb begin
    op_bits   = '0;
    is_binary = 1'b0;
    is_unary  = 1'b0;
    is_muldiv = 1'b0;
    is_halt   = 1'b0;
    case (opcode)
      OP_ADD:  begin op_bits[ALU_ADD]  = 1'b1; is_binary = 1'b1; end
      OP_SUB:  begin op_bits[ALU_SUB]  = 1'b1; is_binary = 1'b1; end
      OP_AND:  begin op_bits[ALU_AND]  = 1'b1; is_binary = 1'b1; end
      OP_OR:   begin op_bits[ALU_OR]   = 1'b1; is_binary = 1'b1; end
      OP_SHR:  begin op_bits[ALU_SHR]  = 1'b1; is_binary = 1'b1; end
      OP_SHRA: begin op_bits[ALU_SHRA] = 1'b1; is_binary = 1'b1; end
      OP_SHL:  begin op_bits[ALU_SHL]  = 1'b1; is_binary = 1'b1; end
      OP_ROR:  begin op_bits[ALU_ROR]  = 1'b1; is_binary = 1'b1; end
      OP_ROL:  begin op_bits[ALU_ROL]  = 1'b1; is_binary = 1'b1; end
      OP_MUL: begin
        op_bits[ALU_MUL] = 1'b1;
        is_binary        = 1'b1;
        is_muldiv        = 1'b1;
      end
      OP_DIV: begin
        op_bits[ALU_DIV] = 1'b1;
        is_binary        = 1'b1;
        is_muldiv        = 1'b1;
      end
      OP_NEG:  begin op_bits[ALU_NEG]  = 1'b1; is_unary  = 1'b1; end
      OP_NOT:  begin op_bits[ALU_NOT]  = 1'b1; is_unary  = 1'b1; end
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // State and wait-counter registers; clear aborts any instruction at once.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_T0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and enable decode; outputs stay zero while clear is low.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    Rin       = '0;
    Rout      = '0;
    PCout     = 1'b0;
    PCin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    MDMuxread = 1'b0;
    mem_read  = 1'b0;
    IncPC     = 1'b0;
    Zhighin   = 1'b0;
    Zlowin    = 1'b0;
    Zhighout  = 1'b0;
    Zlowout   = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    alu_op    = '0;
    halted    = 1'b0;
    fault     = 1'b0;
    if (clear) begin
      case (state_q)
        S_T0: begin
          if (run) begin
            PCout   = 1'b1;
            MARin   = 1'b1;
            IncPC   = 1'b1;
            Zlowin  = 1'b1;
            state_d = S_T1;
          end
        end
        S_T1: begin
          Zlowout  = 1'b1;
          mem_read = 1'b1;
          PCin     = (cnt_q == '0);
          if (mem_ready) begin
            MDMuxread = 1'b1;
            MDRin     = 1'b1;
            state_d   = S_T2;
          end else if (cnt_q == WAIT_LAST) begin
            state_d = S_FAULT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_T2: begin
          MDRout  = 1'b1;
          IRin    = 1'b1;
          state_d = S_T3;
        end
        S_T3: begin
          if (is_binary) begin
            Rout    = rb_onehot;
            Yin     = 1'b1;
            state_d = S_T4;
          end else if (is_unary) begin
            Rout    = rb_onehot;
            alu_op  = op_bits;
            Zhighin = 1'b1;
            Zlowin  = 1'b1;
            state_d = S_T5;
          end else if (is_halt) begin
            state_d = S_HALT;
          end else begin
            state_d = S_T0;
          end
        end
        S_T4: begin
          Rout    = rc_onehot;
          alu_op  = op_bits;
          Zhighin = 1'b1;
          Zlowin  = 1'b1;
          state_d = S_T5;
        end
        S_T5: begin
          Zlowout = 1'b1;
          if (is_muldiv) begin
            LOin    = 1'b1;
            state_d = S_T6;
          end else begin
            Rin     = ra_onehot;
            state_d = S_T0;
          end
        end
        S_T6: begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
          state_d  = S_T0;
        end
        S_HALT:  halted = 1'b1;
        S_FAULT: fault  = 1'b1;
        default: state_d = S_T0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed stimulus with a scoreboard queue of
// hand-computed expected output vectors, checked by a separate monitor.
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic [12:0] alu;
    logic pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in, y_in, md_mux;
    logic mem_rd, inc_pc, zh_in, zl_in, zh_out, zl_out, hi_in, lo_in;
    logic halted, fault;
  } ctl_t;

  typedef struct {
    int    cyc;
    string name;
    ctl_t  exp;
  } sb_item_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic        mem_ready;
  logic [31:0] ir;

  logic [15:0] rin, rout;
  logic [12:0] alu_op;
  logic pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in, y_in, md_mux;
  logic mem_rd, inc_pc, zh_in, zl_in, zh_out, zl_out, hi_in, lo_in;
  logic halted, fault;

  ctl_t     act;
  sb_item_t sb[$];
  int       cycle = 0;
  int       check_cnt = 0;
  int       pass_cnt = 0;

  control_sequencer #(.WAIT_MAX(15), .NREG(16)) dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .IR(ir),
    .Rin(rin), .Rout(rout), .PCout(pc_out), .PCin(pc_in), .MARin(mar_in),
    .MDRin(mdr_in), .MDRout(mdr_out), .IRin(ir_in), .Yin(y_in),
    .MDMuxread(md_mux), .mem_read(mem_rd), .IncPC(inc_pc),
    .Zhighin(zh_in), .Zlowin(zl_in), .Zhighout(zh_out), .Zlowout(zl_out),
    .HIin(hi_in), .LOin(lo_in), .alu_op(alu_op), .halted(halted), .fault(fault)
  );

  assign act = {rin, rout, alu_op, pc_out, pc_in, mar_in, mdr_in, mdr_out, ir_in,
                y_in, md_mux, mem_rd, inc_pc, zh_in, zl_in, zh_out, zl_out,
                hi_in, lo_in, halted, fault};

  always #5 clock = ~clock;

  // Cycle index used to tag scoreboard entries.
  always @(posedge clock) cycle <= cycle + 1;

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'h1234};
  endfunction

  function automatic ctl_t e_t0();
    ctl_t e = '0;
    e.pc_out = 1'b1; e.mar_in = 1'b1; e.inc_pc = 1'b1; e.zl_in = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_t1(input logic first, input logic ready);
    ctl_t e = '0;
    e.zl_out = 1'b1; e.mem_rd = 1'b1; e.pc_in = first;
    e.md_mux = ready; e.mdr_in = ready;
    return e;
  endfunction

  function automatic ctl_t e_t2();
    ctl_t e = '0;
    e.mdr_out = 1'b1; e.ir_in = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_bin_t3(input logic [15:0] r);
    ctl_t e = '0;
    e.rout = r; e.y_in = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_alu(input logic [15:0] r, input logic [12:0] a);
    ctl_t e = '0;
    e.rout = r; e.alu = a; e.zh_in = 1'b1; e.zl_in = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_wb(input logic [15:0] r);
    ctl_t e = '0;
    e.zl_out = 1'b1; e.rin = r;
    return e;
  endfunction

  function automatic ctl_t e_lo();
    ctl_t e = '0;
    e.zl_out = 1'b1; e.lo_in = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_hi();
    ctl_t e = '0;
    e.zh_out = 1'b1; e.hi_in = 1'b1;
    return e;
  endfunction

  function automatic ctl_t e_flags(input logic h, input logic f);
    ctl_t e = '0;
    e.halted = h; e.fault = f;
    return e;
  endfunction

  // Drive one cycle of inputs just after the edge and queue its expectation.
  task automatic applyStimulus(input logic r, input logic mr, input logic [31:0] i,
                               input ctl_t e, input string nm);
    sb_item_t it;
    @(posedge clock);
    #1;
    run       = r;
    mem_ready = mr;
    ir        = i;
    it.cyc    = cycle;
    it.name   = nm;
    it.exp    = e;
    sb.push_back(it);
  endtask

  task automatic checkOutput(input sb_item_t it);
    check_cnt++;
    if (it.cyc == cycle && act === it.exp) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s cyc=%0d/%0d got=%h expected=%h",
               it.name, cycle, it.cyc, act, it.exp);
    end
  endtask

  // Monitor: compare every queued expectation on the falling edge of its cycle.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      checkOutput(sb.pop_front());
    end
  end

  // Hold clear for a few cycles (run high first to prove T0 is gated), then release.
  task automatic doReset();
    applyStimulus(1'b1, 1'b1, ir, '0, "reset_run1");
    applyStimulus(1'b1, 1'b1, ir, '0, "reset_run1");
    applyStimulus(1'b0, 1'b1, ir, '0, "reset_run0");
    @(negedge clock);
    #1 clear = 1'b1;
  endtask

  task automatic enterReset();
    @(negedge clock);
    #1 clear = 1'b0;
    doReset();
  endtask

  task automatic fetch(input string tag, input logic [31:0] old_ir, input logic [31:0] new_ir);
    applyStimulus(1'b1, 1'b1, old_ir, e_t0(), {tag, "_t0"});
    applyStimulus(1'b0, 1'b1, old_ir, e_t1(1'b1, 1'b1), {tag, "_t1"});
    applyStimulus(1'b0, 1'b1, new_ir, e_t2(), {tag, "_t2"});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired with %0d entries pending", sb.size());
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    logic [31:0] ir_add, ir_mul, ir_not, ir_shra, ir_neg, ir_div, ir_nop, ir_halt, ir_sub;
    ir_add  = mk_ir(5'b00011, 4'd2,  4'd5,  4'd6);
    ir_mul  = mk_ir(5'b01111, 4'd1,  4'd3,  4'd4);
    ir_not  = mk_ir(5'b10010, 4'd1,  4'd7,  4'd0);
    ir_shra = mk_ir(5'b01000, 4'd15, 4'd0,  4'd9);
    ir_neg  = mk_ir(5'b10001, 4'd0,  4'd15, 4'd3);
    ir_div  = mk_ir(5'b10000, 4'd3,  4'd1,  4'd2);
    ir_nop  = mk_ir(5'b11111, 4'd6,  4'd6,  4'd6);
    ir_halt = mk_ir(5'b11011, 4'd0,  4'd0,  4'd0);
    ir_sub  = mk_ir(5'b00100, 4'd4,  4'd2,  4'd3);

    clear = 1'b0; run = 1'b1; mem_ready = 1'b1; ir = ir_halt;
    doReset();

    // ADD R2,R5,R6 fetched while IR still shows HALT
    fetch("add", ir_halt, ir_add);
    applyStimulus(1'b0, 1'b1, ir_add, e_bin_t3(16'h0020), "add_t3");
    applyStimulus(1'b0, 1'b1, ir_add, e_alu(16'h0040, 13'h0001), "add_t4");
    applyStimulus(1'b0, 1'b1, ir_add, e_wb(16'h0004), "add_t5");

    // MUL R1,R3,R4
    fetch("mul", ir_add, ir_mul);
    applyStimulus(1'b1, 1'b1, ir_mul, e_bin_t3(16'h0008), "mul_t3");
    applyStimulus(1'b1, 1'b1, ir_mul, e_alu(16'h0010, 13'h0004), "mul_t4");
    applyStimulus(1'b1, 1'b1, ir_mul, e_lo(), "mul_t5");
    applyStimulus(1'b1, 1'b1, ir_mul, e_hi(), "mul_t6");

    // NOT R1,R7
    fetch("not", ir_mul, ir_not);
    applyStimulus(1'b0, 1'b1, ir_not, e_alu(16'h0080, 13'h1000), "not_t3");
    applyStimulus(1'b0, 1'b1, ir_not, e_wb(16'h0002), "not_t5");

    // SHRA R15,R0,R9
    fetch("shra", ir_not, ir_shra);
    applyStimulus(1'b0, 1'b1, ir_shra, e_bin_t3(16'h0001), "shra_t3");
    applyStimulus(1'b0, 1'b1, ir_shra, e_alu(16'h0200, 13'h0080), "shra_t4");
    applyStimulus(1'b0, 1'b1, ir_shra, e_wb(16'h8000), "shra_t5");

    // NEG R0,R15
    fetch("neg", ir_shra, ir_neg);
    applyStimulus(1'b0, 1'b1, ir_neg, e_alu(16'h8000, 13'h0800), "neg_t3");
    applyStimulus(1'b0, 1'b1, ir_neg, e_wb(16'h0001), "neg_t5");

    // DIV R3,R1,R2
    fetch("div", ir_neg, ir_div);
    applyStimulus(1'b0, 1'b1, ir_div, e_bin_t3(16'h0002), "div_t3");
    applyStimulus(1'b0, 1'b1, ir_div, e_alu(16'h0004, 13'h0008), "div_t4");
    applyStimulus(1'b0, 1'b1, ir_div, e_lo(), "div_t5");
    applyStimulus(1'b0, 1'b1, ir_div, e_hi(), "div_t6");

    // Three wait cycles in T1, then a NOP
    applyStimulus(1'b1, 1'b0, ir_div, e_t0(), "wait3_t0");
    applyStimulus(1'b0, 1'b0, ir_div, e_t1(1'b1, 1'b0), "wait3_t1_first");
    applyStimulus(1'b0, 1'b0, ir_div, e_t1(1'b0, 1'b0), "wait3_t1_hold");
    applyStimulus(1'b0, 1'b0, ir_div, e_t1(1'b0, 1'b0), "wait3_t1_hold");
    applyStimulus(1'b0, 1'b1, ir_div, e_t1(1'b0, 1'b1), "wait3_t1_ready");
    applyStimulus(1'b0, 1'b1, ir_nop, e_t2(), "wait3_t2");
    applyStimulus(1'b0, 1'b1, ir_nop, '0, "nop_t3");

    // Zero-wait NOP
    fetch("nop", ir_nop, ir_nop);
    applyStimulus(1'b1, 1'b1, ir_nop, '0, "nop2_t3");

    // WAIT_MAX-1 wait cycles still proceed
    applyStimulus(1'b1, 1'b0, ir_nop, e_t0(), "wait14_t0");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 1'b0, ir_nop, e_t1(i == 0, 1'b0), "wait14_t1");
    end
    applyStimulus(1'b0, 1'b1, ir_nop, e_t1(1'b0, 1'b1), "wait14_ready");
    applyStimulus(1'b0, 1'b1, ir_nop, e_t2(), "wait14_t2");
    applyStimulus(1'b0, 1'b1, ir_nop, '0, "wait14_t3");

    // WAIT_MAX wait cycles end in FAULT, which holds until clear
    applyStimulus(1'b1, 1'b0, ir_nop, e_t0(), "wait15_t0");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 1'b0, ir_nop, e_t1(i == 0, 1'b0), "wait15_t1");
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, ir_add, e_flags(1'b0, 1'b1), "fault_hold");
    end
    enterReset();

    // HALT is absorbing
    fetch("halt", ir_add, ir_halt);
    applyStimulus(1'b1, 1'b1, ir_halt, '0, "halt_t3");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, ir_add, e_flags(1'b1, 1'b0), "halt_hold");
    end
    enterReset();

    // run low keeps the unit idle
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, ir_add, '0, "idle_run0");
    end

    // SUB aborted by clear in T4
    fetch("sub", ir_add, ir_sub);
    applyStimulus(1'b0, 1'b1, ir_sub, e_bin_t3(16'h0004), "sub_t3");
    begin
      sb_item_t it;
      @(posedge clock);
      #1;
      clear     = 1'b0;
      run       = 1'b0;
      it.cyc    = cycle;
      it.name   = "midreset_async";
      it.exp    = '0;
      sb.push_back(it);
      @(negedge clock);
      #1 clear = 1'b1;
    end
    applyStimulus(1'b0, 1'b1, ir_sub, '0, "post_reset_t0");
    fetch("rel", ir_sub, ir_nop);
    applyStimulus(1'b0, 1'b1, ir_nop, '0, "rel_t3");
    applyStimulus(1'b0, 1'b1, ir_nop, '0, "final_idle");

    repeat (3) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      check_cnt++;
      $display("[TB] FAIL drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control unit directly upstream of the CPU datapath. It generates every register in/out enable, ALU operation strobe and memory-read control that the datapath consumes.
- Sequences instruction fetch, then decodes the IR value returned by the datapath, then executes register-register ALU instructions and the halt instruction.
- Outputs are Moore-style: decoded from the current state and the IR fields.

Parameters:
- WAIT_MAX, 15: maximum cycles spent in T1 waiting for mem_ready before entering FAULT.
- NREG, 16: number of general-purpose registers; width of the one-hot Rin/Rout vectors.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- run  in  1  start/continue enable, sampled in T0.
- mem_ready  in  1  memory read data valid on Mdatain.
- IR  in  32  IR register output from the datapath.
- Rin  out  NREG  one-hot GP register load enables (R0in..R15in).
- Rout  out  NREG  one-hot GP register bus drive (R0out..R15out).
- PCout, PCin, MARin, MDRin, MDRout, IRin, Yin  out  1 each  datapath enables.
- MDMuxread  out  1  MDR selects Mdatain.
- mem_read  out  1  memory read request.
- IncPC  out  1  ALU computes PC+1.
- Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin  out  1 each  Z/HI/LO enables.
- alu_op  out  13  one-hot, bits [12:0] = NOT,NEG,ROL,ROR,SHL,SHRA,SHR,OR,AND,DIV,MUL,SUB,ADD (ADD is bit 0).
- halted  out  1  high in HALT state.
- fault  out  1  high in FAULT state.

Behaviour:
- IR fields: opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].
- Opcodes, binary ops: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHRA 01000, SHL 01001, ROR 01010, ROL 01011, MUL 01111, DIV 10000.
- Opcodes, unary ops: NEG 10001, NOT 10010.
- Opcode HALT is 11011. All other opcodes are NOPs.
- Reset: while clear is low, state = T0, wait counter = 0, and every output is 0 (including T0 decode). Reset asserted mid-instruction aborts it immediately.
- States: T0, T1, T2, T3, T4, T5, T6, HALT, FAULT. All outputs not listed for a state are 0.
- T0: if run = 0, hold T0 with all outputs 0. If run = 1, assert PCout, MARin, IncPC and Zlowin, then go to T1.
- T1: assert Zlowout, PCin and mem_read.
  - If mem_ready = 1: also assert MDMuxread and MDRin, go to T2, clear the counter.
  - If mem_ready = 0: counter increments. PCin is asserted on the first T1 cycle only.
  - Counter reaching WAIT_MAX with mem_ready still 0 goes to FAULT.
  - mem_read stays high for the whole wait.
- T2: assert MDRout and IRin. The IR input is valid from the next cycle. Next state is T3.
- T3 by opcode:
  - Binary op: assert Rout[Rb] and Yin, go to T4.
  - Unary op: assert Rout[Rb], the alu_op bit, Zhighin and Zlowin, go to T5.
  - HALT: go to HALT.
  - NOP: go to T0.
- T4 (binary op): assert Rout[Rc], the alu_op bit, Zhighin and Zlowin, go to T5.
- T5:
  - MUL/DIV: assert Zlowout and LOin, go to T6.
  - All other ops: assert Zlowout and Rin[Ra], go to T0.
- T6: assert Zhighout and HIin, go to T0.
- Instruction latency, from T0 to the next T0 with zero memory wait:
  - Binary op: 6 cycles.
  - Unary op: 5 cycles.
  - MUL/DIV: 7 cycles.
  - NOP: 4 cycles.
- R0 is writable; there is no special-casing.
- Invariants:
  - At most one *out signal across Rout, PCout, MDRout, Zhighout and Zlowout is high in any cycle.
  - Rin and Rout are each zero or one-hot.
  - At most one alu_op bit or IncPC is high.
- HALT and FAULT are absorbing states; only clear exits them. halted/fault are high only in their state.
- run going low mid-instruction has no effect; it is checked only in T0.
- IR is ignored in T0–T2.

Test Plan:
- Release clear with run = 1, mem_ready = 1: T0 shows PCout = MARin = IncPC = Zlowin = 1; T1 shows MDRin = MDMuxread = 1; T2 shows IRin = 1.
- IR = ADD, Ra = 2, Rb = 5, Rc = 6: T3 Rout = 0x0020 with Yin = 1; T4 Rout = 0x0040 with alu_op = 0x0001; T5 Rin = 0x0004; back in T0 after 6 cycles.
- IR = MUL, Rb = 3, Rc = 4: T5 shows Zlowout = LOin = 1; T6 shows Zhighout = HIin = 1; T0 after 7 cycles. IR = NOT, Ra = 1, Rb = 7: alu_op = 0x1000 in T3; T4 is skipped.
- mem_ready held low for 3 cycles in T1: stays in T1 with mem_read = 1, PCin on the first cycle only, then proceeds. mem_ready held low for WAIT_MAX cycles: fault = 1 and held until clear.
- IR = HALT: halted = 1 and all enables 0 indefinitely. Drive clear low mid-T4: all outputs go 0 asynchronously; T0 on release.
- run = 0 after reset: no enables asserted for 20 cycles. Opcode 11111 (NOP): T0 → T1 → T2 → T3 → T0 with no Rin/Rout/Yin asserted in T3.
